// File: rtl/fb_fetch.sv
// Framebuffer fetch engine: on each frame start, streams PIXELS words from memory
// into the scanout pixel FIFO, with bounded outstanding reads and FIFO-level throttling.
module fb_fetch #(
  parameter int FB_BASE         = 0,
  parameter int PIXELS          = 384000,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_restart,
  output logic [18:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic [23:0] fifo_data,
  output logic        fifo_wrreq,
  input  logic        fifo_wrfull,
  input  logic [8:0]  fifo_wrusedw,
  output logic        busy,
  output logic        overflow
);

  localparam int            OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OUT_ONE    = OW'(1);
  localparam logic [31:0]   LEVEL_MAX  = 32'(FIFO_DEPTH - 4);
  localparam logic [18:0]   ADDR_BASE  = 19'(FB_BASE);
  localparam logic [18:0]   LAST_PIXEL = 19'(PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_restart_d;
  logic          w_restart_s;
  logic          w_restart_fall;
  logic          r_mem_read;
  logic          w_mem_read_next;
  logic [18:0]   r_address;
  logic [18:0]   r_issued;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] w_out_next;
  logic          w_accept;
  logic          w_return;
  logic          w_write_next;
  logic          w_room;
  logic [31:0]   w_level;
  logic          r_fifo_wrreq;
  logic [23:0]   r_fifo_data;
  logic          r_overflow;
  logic [7:0]    w_unused_bits;

  assign w_restart_s    = r_sync2;
  assign w_restart_fall = r_restart_d & ~r_sync2;
  assign w_accept       = r_mem_read & ~mem_waitrequest;
  // Returns seen with nothing outstanding belong to reads issued before a reset.
  assign w_return       = mem_readdatavalid & (r_outstanding != '0);
  assign w_unused_bits  = mem_readdata[31:24];

  // Gate on the first synchronizer stage too, so a write can never land in the
  // same cycle that restart_s rises and the FIFO is being cleared.
  assign w_write_next = mem_readdatavalid
                      & ((r_state == S_FETCH) | (r_state == S_DONE))
                      & ~r_sync1 & ~r_sync2;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !w_return) begin
      w_out_next = r_outstanding + OUT_ONE;
    end else if (!w_accept && w_return) begin
      w_out_next = r_outstanding - OUT_ONE;
    end
  end

  // Next-cycle FIFO occupancy bound: current level, reads still owed, and the
  // writes sitting in the output register that wrusedw has not yet reflected.
  assign w_level = 32'(fifo_wrusedw) + 32'(w_out_next)
                 + 32'(w_write_next) + 32'(r_fifo_wrreq);
  assign w_room  = (w_out_next < OUT_MAX) && (w_level <= LEVEL_MAX);

  always_comb begin
    w_state_next    = r_state;
    w_mem_read_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_restart_fall) begin
          w_state_next    = S_FETCH;
          w_mem_read_next = w_room;
        end
      end
      S_FETCH: begin
        if (r_mem_read && mem_waitrequest) begin
          w_mem_read_next = 1'b1;
        end else if (w_restart_s) begin
          w_state_next = (w_out_next != '0) ? S_DRAIN : S_IDLE;
        end else if (w_accept && (r_issued == LAST_PIXEL)) begin
          w_state_next = S_DONE;
        end else begin
          w_mem_read_next = w_room;
        end
      end
      S_DONE: begin
        if (w_restart_s) begin
          w_state_next = (w_out_next != '0) ? S_DRAIN : S_IDLE;
        end else if (r_outstanding == '0) begin
          w_state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == '0) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_restart_d   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_address     <= ADDR_BASE;
      r_issued      <= '0;
      r_outstanding <= '0;
      r_fifo_wrreq  <= 1'b0;
      r_fifo_data   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_sync1       <= frame_restart;
      r_sync2       <= r_sync1;
      r_restart_d   <= r_sync2;
      r_mem_read    <= w_mem_read_next;
      r_outstanding <= w_out_next;

      if ((r_state == S_IDLE) && (w_state_next == S_FETCH)) begin
        r_address <= ADDR_BASE;
        r_issued  <= '0;
      end else if (w_accept) begin
        r_address <= r_address + 19'd1;
        r_issued  <= r_issued + 19'd1;
      end

      r_fifo_wrreq <= w_write_next;
      if (w_write_next) begin
        r_fifo_data <= mem_readdata[23:0];
      end

      if (r_fifo_wrreq && fifo_wrfull) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign mem_address = r_address;
  assign mem_read    = r_mem_read;
  assign fifo_data   = r_fifo_data;
  assign fifo_wrreq  = r_fifo_wrreq;
  assign busy        = (r_state != S_IDLE);
  assign overflow    = r_overflow;

endmodule
